p_mul_arbiter: RTL and testbench
================================

# p_mul_arbiter

Shares one packed multiplier (p_mul) between two requesters, e.g. the XCrypto instruction issue path and a background multi-precision sequencer. It accepts requests on two valid/ready ports and picks one winner using round-robin or fixed priority. The winner's operation is then forwarded to the multiplier, and the grant stays locked until the multiplier completes. The block sits between the requesters and the p_mul instance and adds no arithmetic.

## Interface
- FAIR, default 1: 1 = round-robin between requesters; 0 = fixed priority, requester 0 always wins.
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rqN_valid  in  1  (N = 0,1) request valid; held with stable operands until rqN_ready.
- rqN_ready  out  1  one-cycle completion pulse; rqN_result is valid in the same cycle.
- rqN_mul_l, rqN_mul_h, rqN_clmul  in  1 each  operation select.
- rqN_pw  in  5  one-hot pack width: bit0 = 32, bit1 = 16, bit2 = 8, bit3 = 4, bit4 = 2.
- rqN_crs1, rqN_crs2  in  32 each  operands.
- rqN_result  out  32  result; zero unless rqN_ready.
- mul_valid  out  1  request to the multiplier.
- mul_ready  in  1  multiplier completion; mul_result is valid in the same cycle.
- mul_mul_l, mul_mul_h, mul_clmul  out  1 each  forwarded operation select.
- mul_pw  out  5  forwarded pack width.
- mul_crs1, mul_crs2  out  32 each  forwarded operands.
- mul_result  in  32  multiplier result.
- busy  out  1  high while in BUSY.
- grant  out  1  index of the current or last granted requester.

## Operation
- Registers:
  - state: IDLE or BUSY.
  - grant: 1 bit.
  - prio: 1 bit, the preferred requester for the next arbitration.
- IDLE:
  - If no rqN_valid is high, remain in IDLE.
  - If exactly one rqN_valid is high, grant <= N and state <= BUSY.
  - If both are high and FAIR=1, grant <= prio.
  - If both are high and FAIR=0, grant <= 0.
- BUSY forwarding:
  - mul_valid = rq[grant]_valid.
  - mul_* operation fields and operands = rq[grant]_*, passed through combinationally.
- BUSY completion, on mul_valid && mul_ready:
  - rq[grant]_ready = 1 and rq[grant]_result = mul_result, combinationally in that cycle.
  - state <= IDLE.
  - If FAIR=1, prio <= ~grant.
- BUSY abort: if rq[grant]_valid is low, mul_valid drops in the same cycle and state <= IDLE. No ready pulse is issued and prio is unchanged.
- Outside BUSY:
  - mul_valid = 0.
  - All mul_* outputs = 0.
  - Both rqN_ready = 0 and both rqN_result = 0.
- The non-granted requester never sees ready and never has its operands forwarded. Its valid is simply left pending.
- rqN_mul_h is forwarded as given. The arbiter does not check the one-hot encoding of pw or the mutual exclusion of mul_l/mul_h.

## Timing
- Reset values:
  - state = IDLE, grant = 0, prio = 0, busy = 0.
  - mul_valid = 0 and all mul_* = 0.
  - rqN_ready = 0 and rqN_result = 0.
- Arbitration latency: 1 cycle. A request seen in IDLE at edge k drives mul_valid from cycle k+1.
- Requester latency = 1 + multiplier latency. After each completion there is at least one IDLE cycle, so back-to-back operations are spaced by one bubble.
- If a completion and a new request from the other requester occur in the same cycle, the new request is arbitrated in the following IDLE cycle.
- If mul_ready arrives while the arbiter is in IDLE or mul_valid = 0, it is ignored.
- Reset asserted in BUSY: state returns to IDLE at that edge and prio is cleared. The multiplier must be reset or aborted by its own valid drop, since mul_valid is 0 from the next cycle on.
- There is no combinational path from rqN_valid to mul_valid in IDLE.

## Test plan
- Single request:
  - Stimulus: rq0 with pw=00001, mul_l=1, crs1=3, crs2=5, while rq1 is idle.
  - Response: mul_valid rises one cycle later with crs1=3, crs2=5 forwarded. On mul_ready, rq0_ready=1 and rq0_result=0x0000000F. rq1_ready stays 0.
- Simultaneous first requests, FAIR=1, after reset:
  - Stimulus: rq0 = 2*2, rq1 = 2*3.
  - Response: rq0 is served first (result 4), then rq1 after one IDLE bubble (result 6). grant sequence is 0,1.
- Fairness under saturation, FAIR=1:
  - Stimulus: both rqN_valid held high continuously for 8 operations.
  - Response: grants alternate 0,1,0,1,... with exactly one IDLE cycle between operations.
- Fixed priority, FAIR=0:
  - Stimulus: both requesters valid for 4 operations.
  - Response: all 4 go to rq0 and rq1_ready stays 0. rq1 is served only once rq0_valid drops.
- Mid-operation reset:
  - Stimulus: reset asserted while BUSY with grant=1.
  - Response: in the next cycle state=IDLE, mul_valid=0, busy=0, grant=0, prio=0 and both rqN_ready=0.
- Abort:
  - Stimulus: the granted requester drops valid while BUSY.
  - Response: mul_valid drops in the same cycle, state is IDLE next cycle, there is no ready pulse, and prio is unchanged.

Source files
------------

// File: rtl/p_mul_arbiter.sv
// p_mul_arbiter
// Shares one packed multiplier (p_mul) between two requesters. One winner is
// picked in IDLE (round-robin when FAIR=1, requester 0 first when FAIR=0). The
// grant is held until the multiplier completes or the winner drops its valid.
// No arithmetic is done here; operands and results pass straight through.
//
// Ports
//   clock, reset                 : clock, synchronous active-high reset
//   rqN_valid / rqN_ready        : requester handshake; ready is a 1-cycle
//                                  completion pulse with rqN_result
//   rqN_mul_l/mul_h/clmul/pw     : operation select and one-hot pack width
//   rqN_crs1/crs2                : operands
//   rqN_result                   : result, zero unless rqN_ready
//   mul_valid / mul_ready        : multiplier handshake
//   mul_mul_l/mul_h/clmul/pw     : forwarded operation select
//   mul_crs1/crs2                : forwarded operands
//   mul_result                   : multiplier result
//   busy                         : high while an operation is granted
//   grant                        : index of the current or last winner
module p_mul_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        rq0_valid,
  output logic        rq0_ready,
  input  logic        rq0_mul_l,
  input  logic        rq0_mul_h,
  input  logic        rq0_clmul,
  input  logic [4:0]  rq0_pw,
  input  logic [31:0] rq0_crs1,
  input  logic [31:0] rq0_crs2,
  output logic [31:0] rq0_result,

  input  logic        rq1_valid,
  output logic        rq1_ready,
  input  logic        rq1_mul_l,
  input  logic        rq1_mul_h,
  input  logic        rq1_clmul,
  input  logic [4:0]  rq1_pw,
  input  logic [31:0] rq1_crs1,
  input  logic [31:0] rq1_crs2,
  output logic [31:0] rq1_result,

  output logic        mul_valid,
  input  logic        mul_ready,
  output logic        mul_mul_l,
  output logic        mul_mul_h,
  output logic        mul_clmul,
  output logic [4:0]  mul_pw,
  output logic [31:0] mul_crs1,
  output logic [31:0] mul_crs2,
  input  logic [31:0] mul_result,

  output logic        busy,
  output logic        grant
);

  localparam int NUM_RQ = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef struct packed {
    logic        mul_l;
    logic        mul_h;
    logic        clmul;
    logic [4:0]  pw;
    logic [31:0] crs1;
    logic [31:0] crs2;
  } op_t;

  // Requesters gathered into indexable arrays so the grant can select them.
  logic [NUM_RQ-1:0]             rq_valid;
  op_t  [NUM_RQ-1:0]             rq_op;
  logic [NUM_RQ-1:0]             rq_ready;
  logic [NUM_RQ-1:0][31:0]       rq_result;

  assign rq_valid = {rq1_valid, rq0_valid};
  assign rq_op[0] = '{mul_l: rq0_mul_l, mul_h: rq0_mul_h, clmul: rq0_clmul,
                      pw: rq0_pw, crs1: rq0_crs1, crs2: rq0_crs2};
  assign rq_op[1] = '{mul_l: rq1_mul_l, mul_h: rq1_mul_h, clmul: rq1_clmul,
                      pw: rq1_pw, crs1: rq1_crs1, crs2: rq1_crs2};

  logic [0:0] state_q, state_d;
  logic       grant_q, grant_d;
  logic       prio_q,  prio_d;

  logic busy_w;
  logic sel_valid;
  op_t  sel_op;
  op_t  fwd_op;
  logic done;

  assign busy_w    = (state_q == ST_BUSY);
  assign sel_valid = rq_valid[grant_q];
  assign sel_op    = rq_op[grant_q];

  // Only a live request may complete; mul_ready on its own is ignored.
  assign done      = busy_w && sel_valid && mul_ready;

  // Fields are forwarded only while BUSY so the multiplier sees zeros otherwise.
  assign fwd_op    = busy_w ? sel_op : '0;
  assign mul_valid = busy_w && sel_valid;
  assign mul_mul_l = fwd_op.mul_l;
  assign mul_mul_h = fwd_op.mul_h;
  assign mul_clmul = fwd_op.clmul;
  assign mul_pw    = fwd_op.pw;
  assign mul_crs1  = fwd_op.crs1;
  assign mul_crs2  = fwd_op.crs2;

  // Completion steering: only the granted requester ever sees ready/result.
  for (genvar i = 0; i < NUM_RQ; i++) begin : g_rq
    assign rq_ready[i]  = done && (grant_q == 1'(i));
    assign rq_result[i] = rq_ready[i] ? mul_result : '0;
  end

  assign rq0_ready  = rq_ready[0];
  assign rq1_ready  = rq_ready[1];
  assign rq0_result = rq_result[0];
  assign rq1_result = rq_result[1];

  assign busy  = busy_w;
  assign grant = grant_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    case (state_q)
      ST_IDLE: begin
        // Arbitration is registered: valid in IDLE never reaches mul_valid
        // in the same cycle.
        if (|rq_valid) begin
          state_d = ST_BUSY;
          if (&rq_valid) grant_d = FAIR ? prio_q : 1'b0;
          else           grant_d = rq_valid[1];
        end
      end
      ST_BUSY: begin
        if (!sel_valid) begin
          // Abort: winner withdrew; preference is left as it was.
          state_d = ST_IDLE;
        end else if (mul_ready) begin
          state_d = ST_IDLE;
          if (FAIR) prio_d = ~grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
    end
  end

endmodule

// File: tb/tb_p_mul_arbiter.sv
module tb_p_mul_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        rq0_valid, rq1_valid;
  logic [31:0] rq0_crs1, rq0_crs2;
  logic        mul_ready;
  logic [31:0] mul_result;

  // FAIR=1 instance outputs
  logic        fa_rq0_ready, fa_rq1_ready, fa_mul_valid, fa_busy, fa_grant;
  logic [31:0] fa_rq0_result, fa_rq1_result, fa_mul_crs1, fa_mul_crs2;
  logic        fa_mul_l, fa_mul_h, fa_clmul;
  logic [4:0]  fa_pw;
  // FAIR=0 instance outputs
  logic        f0_rq0_ready, f0_rq1_ready, f0_mul_valid, f0_busy, f0_grant;
  logic [31:0] f0_rq0_result, f0_rq1_result, f0_mul_crs1, f0_mul_crs2;
  logic        f0_mul_l, f0_mul_h, f0_clmul;
  logic [4:0]  f0_pw;

  always #5 clock = ~clock;

  p_mul_arbiter #(.FAIR(1'b1)) u_fa (
    .clock(clock), .reset(reset),
    .rq0_valid(rq0_valid), .rq0_ready(fa_rq0_ready), .rq0_mul_l(1'b1), .rq0_mul_h(1'b0),
    .rq0_clmul(1'b0), .rq0_pw(5'b00001), .rq0_crs1(rq0_crs1), .rq0_crs2(rq0_crs2),
    .rq0_result(fa_rq0_result),
    .rq1_valid(rq1_valid), .rq1_ready(fa_rq1_ready), .rq1_mul_l(1'b1), .rq1_mul_h(1'b0),
    .rq1_clmul(1'b0), .rq1_pw(5'b00001), .rq1_crs1(32'd3), .rq1_crs2(32'd2),
    .rq1_result(fa_rq1_result),
    .mul_valid(fa_mul_valid), .mul_ready(mul_ready), .mul_mul_l(fa_mul_l),
    .mul_mul_h(fa_mul_h), .mul_clmul(fa_clmul), .mul_pw(fa_pw),
    .mul_crs1(fa_mul_crs1), .mul_crs2(fa_mul_crs2), .mul_result(mul_result),
    .busy(fa_busy), .grant(fa_grant)
  );

  p_mul_arbiter #(.FAIR(1'b0)) u_f0 (
    .clock(clock), .reset(reset),
    .rq0_valid(rq0_valid), .rq0_ready(f0_rq0_ready), .rq0_mul_l(1'b1), .rq0_mul_h(1'b0),
    .rq0_clmul(1'b0), .rq0_pw(5'b00001), .rq0_crs1(rq0_crs1), .rq0_crs2(rq0_crs2),
    .rq0_result(f0_rq0_result),
    .rq1_valid(rq1_valid), .rq1_ready(f0_rq1_ready), .rq1_mul_l(1'b1), .rq1_mul_h(1'b0),
    .rq1_clmul(1'b0), .rq1_pw(5'b00001), .rq1_crs1(32'd3), .rq1_crs2(32'd2),
    .rq1_result(f0_rq1_result),
    .mul_valid(f0_mul_valid), .mul_ready(mul_ready), .mul_mul_l(f0_mul_l),
    .mul_mul_h(f0_mul_h), .mul_clmul(f0_clmul), .mul_pw(f0_pw),
    .mul_crs1(f0_mul_crs1), .mul_crs2(f0_mul_crs2), .mul_result(mul_result),
    .busy(f0_busy), .grant(f0_grant)
  );

  typedef struct {
    string       name;
    logic        rst, v0, v1, mr;
    logic [31:0] mres, a0, b0;
    logic        e_mv, e_r0, e_r1;
    logic [31:0] e_res0, e_res1;
    logic        e_busy, e_grant;
    logic [31:0] e_crs1, e_crs2;
  } vec_t;

  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(string n, logic rst, logic v0, logic v1, logic mr,
                              logic [31:0] mres, logic [31:0] a0, logic [31:0] b0,
                              logic mv, logic r0, logic r1, logic [31:0] res0,
                              logic [31:0] res1, logic bsy, logic g,
                              logic [31:0] c1, logic [31:0] c2);
    vec_t v;
    v.name = n; v.rst = rst; v.v0 = v0; v.v1 = v1; v.mr = mr; v.mres = mres;
    v.a0 = a0; v.b0 = b0; v.e_mv = mv; v.e_r0 = r0; v.e_r1 = r1;
    v.e_res0 = res0; v.e_res1 = res1; v.e_busy = bsy; v.e_grant = g;
    v.e_crs1 = c1; v.e_crs2 = c2;
    return v;
  endfunction

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s got=%h exp=%h", nm, fld, act, exp);
    end
  endtask

  // One cycle: drive inputs just after the edge, check combinational outputs
  // mid-cycle, then let the next edge happen.
  task automatic cyc(input vec_t v, input bit use_f0);
    reset = v.rst; rq0_valid = v.v0; rq1_valid = v.v1; mul_ready = v.mr;
    mul_result = v.mres; rq0_crs1 = v.a0; rq0_crs2 = v.b0;
    #2;
    if (!use_f0) begin
      chk(v.name, "mul_valid", 32'(fa_mul_valid), 32'(v.e_mv));
      chk(v.name, "rq0_ready", 32'(fa_rq0_ready), 32'(v.e_r0));
      chk(v.name, "rq1_ready", 32'(fa_rq1_ready), 32'(v.e_r1));
      chk(v.name, "rq0_result", fa_rq0_result, v.e_res0);
      chk(v.name, "rq1_result", fa_rq1_result, v.e_res1);
      chk(v.name, "busy", 32'(fa_busy), 32'(v.e_busy));
      chk(v.name, "grant", 32'(fa_grant), 32'(v.e_grant));
      chk(v.name, "mul_crs1", fa_mul_crs1, v.e_crs1);
      chk(v.name, "mul_crs2", fa_mul_crs2, v.e_crs2);
      chk(v.name, "mul_l", 32'(fa_mul_l), 32'(v.e_busy));
    end else begin
      chk(v.name, "mul_valid", 32'(f0_mul_valid), 32'(v.e_mv));
      chk(v.name, "rq0_ready", 32'(f0_rq0_ready), 32'(v.e_r0));
      chk(v.name, "rq1_ready", 32'(f0_rq1_ready), 32'(v.e_r1));
      chk(v.name, "rq0_result", f0_rq0_result, v.e_res0);
      chk(v.name, "rq1_result", f0_rq1_result, v.e_res1);
      chk(v.name, "busy", 32'(f0_busy), 32'(v.e_busy));
      chk(v.name, "grant", 32'(f0_grant), 32'(v.e_grant));
      chk(v.name, "mul_crs1", f0_mul_crs1, v.e_crs1);
      chk(v.name, "mul_crs2", f0_mul_crs2, v.e_crs2);
    end
    @(posedge clock); #1;
  endtask

  vec_t tbl[$];

  initial begin
    reset = 1'b1; rq0_valid = 1'b0; rq1_valid = 1'b0; mul_ready = 1'b0;
    mul_result = '0; rq0_crs1 = '0; rq0_crs2 = '0;
    repeat (2) @(posedge clock);
    #1;

    // name rst v0 v1 mr mres a0 b0 | mv r0 r1 res0 res1 busy grant crs1 crs2
    tbl.push_back(mk("reset_idle",   0,0,0,0,32'h0,   2,2, 0,0,0,0,0,   0,0,0,0));
    tbl.push_back(mk("rdy_in_idle",  0,0,0,1,32'hDEAD,2,2, 0,0,0,0,0,   0,0,0,0));
    tbl.push_back(mk("both_req",     0,1,1,0,32'h0,   2,2, 0,0,0,0,0,   0,0,0,0));
    tbl.push_back(mk("op0_done",     0,1,1,1,32'h4,   2,2, 1,1,0,4,0,   1,0,2,2));
    tbl.push_back(mk("bubble",       0,0,1,0,32'h0,   2,2, 0,0,0,0,0,   0,0,0,0));
    tbl.push_back(mk("op1_wait",     0,0,1,0,32'h0,   2,2, 1,0,0,0,0,   1,1,3,2));
    tbl.push_back(mk("op1_done",     0,0,1,1,32'h6,   2,2, 1,0,1,0,6,   1,1,3,2));
    tbl.push_back(mk("single_req",   0,1,0,0,32'h0,   3,5, 0,0,0,0,0,   0,1,0,0));
    tbl.push_back(mk("single_fwd",   0,1,0,0,32'h0,   3,5, 1,0,0,0,0,   1,0,3,5));
    tbl.push_back(mk("done_new_req", 0,1,1,1,32'hF,   3,5, 1,1,0,32'hF,0,1,0,3,5));
    tbl.push_back(mk("bubble2",      0,0,1,0,32'h0,   3,5, 0,0,0,0,0,   0,0,0,0));
    tbl.push_back(mk("op1_busy",     0,0,1,0,32'h0,   3,5, 1,0,0,0,0,   1,1,3,2));
    tbl.push_back(mk("abort",        0,0,0,1,32'h77,  3,5, 0,0,0,0,0,   1,1,3,2));
    tbl.push_back(mk("after_abort",  0,1,1,0,32'h0,   2,2, 0,0,0,0,0,   0,1,0,0));
    tbl.push_back(mk("prio_kept",    0,1,1,0,32'h0,   2,2, 1,0,0,0,0,   1,1,3,2));
    tbl.push_back(mk("op1_done2",    0,1,1,1,32'h6,   2,2, 1,0,1,0,6,   1,1,3,2));
    tbl.push_back(mk("req0",         0,1,0,0,32'h0,   2,2, 0,0,0,0,0,   0,1,0,0));
    tbl.push_back(mk("op0_done2",    0,1,0,1,32'h4,   2,2, 1,1,0,4,0,   1,0,2,2));
    tbl.push_back(mk("req1",         0,0,1,0,32'h0,   2,2, 0,0,0,0,0,   0,0,0,0));
    tbl.push_back(mk("op1_busy2",    0,0,1,0,32'h0,   2,2, 1,0,0,0,0,   1,1,3,2));
    tbl.push_back(mk("rst_in_busy",  1,0,1,0,32'h0,   2,2, 1,0,0,0,0,   1,1,3,2));
    tbl.push_back(mk("after_rst",    0,0,0,0,32'h0,   2,2, 0,0,0,0,0,   0,0,0,0));
    tbl.push_back(mk("both_post_rst",0,1,1,0,32'h0,   2,2, 0,0,0,0,0,   0,0,0,0));
    tbl.push_back(mk("prio_cleared", 0,1,1,0,32'h0,   2,2, 1,0,0,0,0,   1,0,2,2));
    tbl.push_back(mk("op0_done3",    0,1,1,1,32'h4,   2,2, 1,1,0,4,0,   1,0,2,2));

    foreach (tbl[i]) cyc(tbl[i], 1'b0);

    // Saturation, FAIR=1: prio is 1 after op0_done3, so grants run 1,0,1,...
    begin
      logic prev_g;
      logic g;
      prev_g = 1'b0;
      for (int i = 0; i < 8; i++) begin
        g = (i % 2 == 0) ? 1'b1 : 1'b0;
        cyc(mk("sat_bubble", 0,1,1,0,32'h0, 2,2, 0,0,0,0,0, 0,prev_g,0,0), 1'b0);
        cyc(mk("sat_op", 0,1,1,1, g ? 32'd6 : 32'd4, 2,2,
               1, !g, g, g ? 32'd0 : 32'd4, g ? 32'd6 : 32'd0, 1, g,
               g ? 32'd3 : 32'd2, 32'd2), 1'b0);
        prev_g = g;
      end
    end

    // Fixed priority, FAIR=0 instance.
    reset = 1'b1; rq0_valid = 1'b0; rq1_valid = 1'b0; mul_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      cyc(mk("fix_bubble", 0,1,1,0,32'h0, 2,2, 0,0,0,0,0, 0,0,0,0), 1'b1);
      cyc(mk("fix_op0", 0,1,1,1,32'd4, 2,2, 1,1,0,4,0, 1,0,2,2), 1'b1);
    end
    cyc(mk("fix_rq0_gone", 0,0,1,0,32'h0, 2,2, 0,0,0,0,0, 0,0,0,0), 1'b1);
    cyc(mk("fix_op1", 0,0,1,1,32'd6, 2,2, 1,0,1,0,6, 1,1,3,2), 1'b1);
    cyc(mk("fix_idle", 0,0,0,0,32'h0, 2,2, 0,0,0,0,0, 0,1,0,0), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
